// File: rtl/nap_responder_pkg.sv
// Shared types and constants for the read-only NAP responder.
// AXI response/burst encodings, AR queue entry and FSM states.
package nap_responder_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam int MAX_ID_W  = 16;
  localparam int MAX_IDX_W = 32;

  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic [MAX_IDX_W-1:0] index;
    logic [7:0]           len;
    logic [1:0]           burst;
    logic [1:0]           err;
  } t_ar_req;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } t_rd_state;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } t_wr_state;

endpackage

// File: rtl/nap_responder_bram.sv
// Simple dual-port RAM, one-cycle registered read.
// A same-cycle write and read to one word returns the old contents.
module nap_responder_bram #(
  parameter int W     = 256,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             q
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/nap_responder_readonly.sv
// AXI4 read-only NAP responder: AR/R bursts served from local BRAM,
// writes drained and answered with SLVERR.
module nap_responder_readonly
  import nap_responder_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 28,
  parameter int ID_W      = 8,
  parameter int MEM_DEPTH = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [ID_W-1:0]              arid,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic [3:0]                   arqos,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [DATA_W-1:0]            rdata,
  output logic [ID_W-1:0]              rid,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [ID_W-1:0]              awid,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [7:0]                   awlen,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic                         wlast,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [ID_W-1:0]              bid,
  output logic [1:0]                   bresp,
  input  logic                         i_mem_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_mem_wr_addr,
  input  logic [DATA_W-1:0]            i_mem_wr_data,
  output logic [15:0]                  o_rd_bursts
);

  localparam int MW = $clog2(MEM_DEPTH);
  localparam int SH = $clog2(DATA_W/8);

  t_ar_req           ar_q [2];
  t_ar_req           ar_new, head;
  logic [1:0]        ar_cnt, ar_cnt_nxt;
  logic              ar_wp, ar_rp, ar_push, ar_pop;
  logic              ar_below;
  logic [ADDR_W-1:0] ar_off, ar_word;

  assign {ar_below, ar_off} = {1'b0, araddr} - {1'b0, BASE_ADDR};
  assign ar_word = ar_off >> SH;

  always_comb begin
    ar_new       = '0;
    ar_new.id    = MAX_ID_W'(arid);
    ar_new.index = MAX_IDX_W'(ar_word);
    ar_new.len   = arlen;
    ar_new.burst = arburst;
    if (arburst[1])
      ar_new.err = DECERR;
    else if (ar_below || ar_word >= ADDR_W'(MEM_DEPTH))
      ar_new.err = SLVERR;
    else
      ar_new.err = OKAY;
  end

  assign ar_push    = arvalid && arready;
  assign head       = ar_q[ar_rp];
  assign ar_cnt_nxt = ar_cnt + {1'b0, ar_push} - {1'b0, ar_pop};

  always_ff @(posedge i_clk) begin
    if (ar_push) ar_q[ar_wp] <= ar_new;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ar_cnt  <= '0;
      ar_wp   <= 1'b0;
      ar_rp   <= 1'b0;
      arready <= 1'b0;
    end else begin
      ar_cnt  <= ar_cnt_nxt;
      arready <= ar_cnt_nxt != 2'd2;
      if (ar_push) ar_wp <= ~ar_wp;
      if (ar_pop)  ar_rp <= ~ar_rp;
    end
  end

  t_rd_state           rd_state, rd_next;
  logic [MAX_ID_W-1:0] cur_id, iss_id, inf_id;
  logic [MW-1:0]       cur_idx, rd_addr;
  logic [7:0]          cur_len, cnt;
  logic [1:0]          cur_burst, cur_err, iss_resp, inf_resp;
  logic                issue, iss_last, inf_v, inf_last;
  logic                skid_v, sk_last, r_pop, space;
  logic [DATA_W-1:0]   bram_q, in_data, sk_data;
  logic [ID_W-1:0]     sk_id;
  logic [1:0]          sk_resp;

  // Issue only if the beat is guaranteed a slot in the two-deep output stage
  assign r_pop = rvalid && rready;
  assign space = (2'(rvalid) + 2'(skid_v) + 2'(inf_v)) <= (2'(r_pop) + 2'd1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rd_state <= RD_IDLE;
    else            rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE:  if (ar_pop && head.len != 8'd0) rd_next = RD_BURST;
      RD_BURST: if (issue && iss_last) rd_next = RD_IDLE;
      default:  rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    ar_pop   = 1'b0;
    issue    = 1'b0;
    iss_last = 1'b0;
    iss_id   = cur_id;
    iss_resp = cur_err;
    rd_addr  = cur_idx;
    unique case (rd_state)
      RD_IDLE: begin
        if (ar_cnt != 2'd0 && space) begin
          ar_pop   = 1'b1;
          issue    = 1'b1;
          rd_addr  = head.index[MW-1:0];
          iss_last = head.len == 8'd0;
          iss_id   = head.id;
          iss_resp = head.err;
        end
      end
      RD_BURST: begin
        if (space) begin
          issue    = 1'b1;
          iss_last = cnt == cur_len;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cur_id    <= '0;
      cur_idx   <= '0;
      cur_len   <= '0;
      cur_burst <= '0;
      cur_err   <= '0;
      cnt       <= '0;
      inf_v     <= 1'b0;
      inf_id    <= '0;
      inf_resp  <= '0;
      inf_last  <= 1'b0;
    end else begin
      if (ar_pop) begin
        cur_id    <= head.id;
        cur_len   <= head.len;
        cur_burst <= head.burst;
        cur_err   <= head.err;
        cnt       <= 8'd1;
        cur_idx   <= head.index[MW-1:0] + MW'(head.burst == INCR);
      end else if (issue) begin
        cnt     <= cnt + 8'd1;
        cur_idx <= cur_idx + MW'(cur_burst == INCR);
      end
      inf_v <= issue;
      if (issue) begin
        inf_id   <= iss_id;
        inf_resp <= iss_resp;
        inf_last <= iss_last;
      end
    end
  end

  nap_responder_bram #(
    .W     (DATA_W),
    .DEPTH (MEM_DEPTH)
  ) u_bram (
    .clk   (i_clk),
    .we    (i_mem_wr_en),
    .waddr (i_mem_wr_addr),
    .wdata (i_mem_wr_data),
    .re    (issue),
    .raddr (rd_addr),
    .q     (bram_q)
  );

  assign in_data = (inf_resp == OKAY) ? bram_q : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rvalid      <= 1'b0;
      rdata       <= '0;
      rid         <= '0;
      rresp       <= '0;
      rlast       <= 1'b0;
      skid_v      <= 1'b0;
      sk_data     <= '0;
      sk_id       <= '0;
      sk_resp     <= '0;
      sk_last     <= 1'b0;
      o_rd_bursts <= '0;
    end else begin
      if (r_pop && rlast) o_rd_bursts <= o_rd_bursts + 16'd1;
      if (!rvalid || (r_pop && !skid_v)) begin
        rvalid <= inf_v;
        if (inf_v) begin
          rdata <= in_data;
          rid   <= ID_W'(inf_id);
          rresp <= inf_resp;
          rlast <= inf_last;
        end
      end else if (r_pop) begin
        rdata  <= sk_data;
        rid    <= sk_id;
        rresp  <= sk_resp;
        rlast  <= sk_last;
        skid_v <= inf_v;
        if (inf_v) begin
          sk_data <= in_data;
          sk_id   <= ID_W'(inf_id);
          sk_resp <= inf_resp;
          sk_last <= inf_last;
        end
      end else if (inf_v) begin
        skid_v  <= 1'b1;
        sk_data <= in_data;
        sk_id   <= ID_W'(inf_id);
        sk_resp <= inf_resp;
        sk_last <= inf_last;
      end
    end
  end

  t_wr_state wr_state, wr_next;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) wr_state <= WR_IDLE;
    else            wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      WR_IDLE: if (awvalid && awready) wr_next = WR_DATA;
      WR_DATA: if (wvalid && wready && wlast) wr_next = WR_RESP;
      WR_RESP: if (bvalid && bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      bid     <= '0;
    end else begin
      awready <= wr_next == WR_IDLE;
      wready  <= wr_next == WR_DATA;
      bvalid  <= wr_next == WR_RESP;
      bresp   <= (wr_next == WR_RESP) ? SLVERR : OKAY;
      if (awvalid && awready) bid <= awid;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{awaddr, awlen, arsize, arqos, head, inf_id, cur_id};

endmodule

// File: doc/nap_responder_readonly.md
Name: nap_responder_readonly

Overview:
- AXI4 read-only responder (slave end) for the NAP read protocol.
- Serves AR/R bursts from a local dual-port BRAM that user logic fills through a simple write port.
- Used as a loopback/bring-up target for read-only NAP initiators.
- Any AXI write is drained and answered with SLVERR.

Parameters:
- DATA_W, 256, AXI data width; bytes per beat = DATA_W/8.
- ADDR_W, 28, AXI address width.
- ID_W, 8, AXI ID width.
- MEM_DEPTH, 512, BRAM words, power of two.
- BASE_ADDR, 28'h0, byte address mapped to word 0.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- arvalid in 1 / arready out 1 / araddr in ADDR_W / arid in ID_W / arlen in 8 / arsize in 3 / arburst in 2 / arqos in 4: read address channel
- rvalid out 1 / rready in 1 / rdata out DATA_W / rid out ID_W / rresp out 2 / rlast out 1: read data channel
- awvalid in 1 / awready out 1 / awid in ID_W / awaddr in ADDR_W / awlen in 8: write address channel (drained)
- wvalid in 1 / wready out 1 / wlast in 1: write data channel (wdata/wstrb ignored)
- bvalid out 1 / bready in 1 / bid out ID_W / bresp out 2: write response channel
- i_mem_wr_en in 1 / i_mem_wr_addr in log2(MEM_DEPTH) / i_mem_wr_data in DATA_W: local fill port
- o_rd_bursts out 16: count of completed read bursts, wraps at 0xFFFF

Behaviour:
- Reset: arready=0, rvalid=0, rlast=0, rdata=0, rid=0, rresp=0, awready=0, wready=0, bvalid=0, bid=0, bresp=0, o_rd_bursts=0, both FSMs idle. BRAM contents are not reset.
- AR queue: 2-entry FIFO. arready = !full, registered.
- Read FSM, RD_IDLE:
  - Pops the queue head and latches id, len, burst.
  - Word index = (araddr - BASE_ADDR) >> log2(DATA_W/8).
  - Goes to RD_BURST.
- Read FSM, RD_BURST:
  - Issues one BRAM read per cycle unless the output stage is full.
  - BRAM has 1-cycle latency; 2-entry output skid buffer.
  - Sustains 1 beat/cycle while rready=1.
- Latency: AR handshake in cycle N with empty FIFO and idle FSM -> first rvalid in cycle N+3.
- Beat count = arlen+1. rlast=1 only on beat arlen.
- Returns to RD_IDLE when the last beat's read is issued. The next burst may start overlapping the tail drain. o_rd_bursts increments on the rlast handshake.
- Addressing:
  - INCR (01): index+1 per beat, wraps modulo MEM_DEPTH.
  - FIXED (00): same index every beat.
  - WRAP (10) or reserved (11): every beat rresp=DECERR (2'b11), rdata=0.
- araddr < BASE_ADDR, or start index >= MEM_DEPTH: rresp=SLVERR (2'b10) and rdata=0 for all beats. Beat count is unchanged.
- arsize below full width: full word returned, rresp=OKAY. arqos is ignored.
- R outputs hold stable while rvalid=1 and rready=0 (AXI rule). rid equals the burst's arid.
- Local write and AXI read to the same word in the same cycle: read returns old data (read-first).
- Write FSM:
  - WR_IDLE (awready=1): AW handshake latches awid, goes to WR_DATA.
  - WR_DATA (wready=1): accepts beats until wlast handshake, goes to WR_RESP. awlen is not checked against the beat count.
  - WR_RESP: bvalid=1, bresp=2'b10, bid=latched awid. Holds until bready, then WR_IDLE.
- Write and read FSMs are fully independent.
- Reset asserted mid-burst: outputs return to reset values immediately, FIFO is flushed, the in-flight burst is abandoned.

Decomposition:
- Package nap_responder_pkg holds:
  - AXI resp constants OKAY/SLVERR/DECERR.
  - Burst constants FIXED/INCR/WRAP.
  - Typedef t_ar_req {id, index, len, burst, err}.
  - Enums for the read and write FSM states.
- One sub-module, nap_responder_bram: simple dual-port, 1-cycle read, read-first.

Test Plan:
- Fill words 0..15 with value=index. AR araddr=BASE, arlen=15, INCR, arid=8'h5A, rready=1 -> 16 beats data 0..15, rid=5A, rresp=0, rlast on beat 16 only, first rvalid at AR cycle+3, no bubbles, o_rd_bursts=1.
- Same burst with rready toggling 1-0-1-0 -> data order and values unchanged, no beat lost or duplicated, outputs stable while stalled.
- AR arlen=3 FIXED at word 7 (value 7) -> four beats of 7. Then INCR starting at word MEM_DEPTH-2, arlen=3 -> 510,511,0,1.
- Two back-to-back ARs (ids 1,2; arlen 0 and 1) presented on consecutive cycles -> both accepted without stall. Responses in order id1 (1 beat), id2 (2 beats).
- AR with arburst=WRAP -> all beats DECERR, data 0. AR with araddr=BASE + MEM_DEPTH*32 -> SLVERR with arlen+1 beats.
- AW awid=3 plus 4 W beats with wlast on the 4th, bready held 0 for 5 cycles -> bvalid stays 1, bid=3, bresp=2'b10, cleared after bready. A concurrent read burst is unaffected.
